// File: rtl/fixed_order_selector.sv
// Purpose : picks the fixed-predictor order (0..4) with the smallest sum of |residual| over one block.
// Latency : 6 clocks from the last accepted sample of a block to the oDone pulse.
// Backpres: none; a sample is taken on every edge with iEnable && iValid, and blocks stream back-to-back.
//
// Ports:
//   iClock, iReset             rising-edge clock, synchronous active-high reset
//   iEnable, iValid            sample accept qualifiers
//   iResidual0..iResidual4     signed residuals of fixed orders 0..4 for the same sample
//   oDone                      one-cycle pulse when oBestOrder/oBestSum refer to the block just finished
//   oBestOrder, oBestSum       winning order and its saturated sum (held until the next oDone)
module fixed_order_selector #(
    parameter int BLOCK_SIZE = 4096,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  iEnable,
    input  logic                  iValid,
    input  logic signed [15:0]    iResidual0,
    input  logic signed [15:0]    iResidual1,
    input  logic signed [15:0]    iResidual2,
    input  logic signed [15:0]    iResidual3,
    input  logic signed [15:0]    iResidual4,
    output logic                  oDone,
    output logic [2:0]            oBestOrder,
    output logic [ACC_WIDTH-1:0]  oBestSum
);

    localparam int                   CNT_W    = $clog2(BLOCK_SIZE);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(BLOCK_SIZE - 1);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX  = '1;

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    logic signed [15:0]   res      [5];
    logic [16:0]          abs_q    [5];
    logic                 s1_vld;
    logic [ACC_WIDTH-1:0] acc      [5];
    logic [ACC_WIDTH-1:0] acc_next [5];
    logic [ACC_WIDTH-1:0] snap     [5];
    logic [CNT_W-1:0]     cnt;
    logic                 block_end;

    state_t               state;
    logic [2:0]           j;
    logic [2:0]           best_order;
    logic [ACC_WIDTH-1:0] best_sum;

    assign res[0] = iResidual0;
    assign res[1] = iResidual1;
    assign res[2] = iResidual2;
    assign res[3] = iResidual3;
    assign res[4] = iResidual4;

    // 17 bits so that |-32768| = 32768 is representable.
    function automatic logic [16:0] abs17(input logic signed [15:0] r);
        logic [16:0] e;
        e = {r[15], r};
        return r[15] ? (~e + 17'd1) : e;
    endfunction

    function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                     input logic [16:0]          b);
        logic [ACC_WIDTH:0] s;
        s = {1'b0, a} + (ACC_WIDTH+1)'(b);
        return s[ACC_WIDTH] ? ACC_MAX : s[ACC_WIDTH-1:0];
    endfunction

    always_comb begin
        for (int k = 0; k < 5; k++) begin
            acc_next[k] = sat_add(acc[k], abs_q[k]);
        end
    end

    assign block_end = s1_vld && (cnt == CNT_LAST);

    // Stage 1: register absolute values of the accepted sample.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            s1_vld <= 1'b0;
            for (int k = 0; k < 5; k++) abs_q[k] <= '0;
        end else begin
            s1_vld <= iEnable && iValid;
            if (iEnable && iValid) begin
                for (int k = 0; k < 5; k++) abs_q[k] <= abs17(res[k]);
            end
        end
    end

    // Stage 2: accumulate; on the last sample of a block, move the final sums
    // into snap and zero the accumulators so the next block starts clean.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            cnt <= '0;
            for (int k = 0; k < 5; k++) begin
                acc[k]  <= '0;
                snap[k] <= '0;
            end
        end else if (s1_vld) begin
            if (block_end) begin
                cnt <= '0;
                for (int k = 0; k < 5; k++) begin
                    snap[k] <= acc_next[k];
                    acc[k]  <= '0;
                end
            end else begin
                cnt <= cnt + 1'b1;
                for (int k = 0; k < 5; k++) acc[k] <= acc_next[k];
            end
        end
    end

    // Compare FSM: seeded with order 0 at block end, then one order per clock.
    // Strict less-than keeps the lower order on ties.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state      <= IDLE;
            j          <= 3'd0;
            best_order <= 3'd0;
            best_sum   <= '0;
            oDone      <= 1'b0;
            oBestOrder <= 3'd0;
            oBestSum   <= '0;
        end else begin
            oDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (block_end) begin
                        state      <= CMP;
                        j          <= 3'd1;
                        best_order <= 3'd0;
                        best_sum   <= acc_next[0];
                    end
                end
                CMP: begin
                    if (snap[j] < best_sum) begin
                        best_order <= j;
                        best_sum   <= snap[j];
                    end
                    if (j == 3'd4) state <= DONE;
                    j <= j + 3'd1;
                end
                DONE: begin
                    oDone      <= 1'b1;
                    oBestOrder <= best_order;
                    oBestSum   <= best_sum;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_order_selector.sv
module tb_fixed_order_selector;

    localparam int     BS   = 8;
    localparam int     AW   = 17;
    localparam longint MAXS = (longint'(1) << AW) - 1;

    logic                 iClock;
    logic                 iReset;
    logic                 iEnable;
    logic                 iValid;
    logic signed [15:0]   iResidual0, iResidual1, iResidual2, iResidual3, iResidual4;
    logic                 oDone;
    logic [2:0]           oBestOrder;
    logic [AW-1:0]        oBestSum;

    fixed_order_selector #(.BLOCK_SIZE(BS), .ACC_WIDTH(AW)) dut (
        .iClock     (iClock),
        .iReset     (iReset),
        .iEnable    (iEnable),
        .iValid     (iValid),
        .iResidual0 (iResidual0),
        .iResidual1 (iResidual1),
        .iResidual2 (iResidual2),
        .iResidual3 (iResidual3),
        .iResidual4 (iResidual4),
        .oDone      (oDone),
        .oBestOrder (oBestOrder),
        .oBestSum   (oBestSum)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    typedef struct {
        int     order;
        longint sum;
        longint cyc;
    } exp_t;

    exp_t   expq[$];
    int     checks = 0;
    int     errors = 0;
    longint cyc    = 0;
    longint msum[5];
    int     mcnt   = 0;
    bit     done_prev = 1'b0;

    always @(posedge iClock) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic longint absv(input logic [15:0] r);
        longint v;
        v = longint'($signed(r));
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [4:0][15:0] mk(input int a0, input int a1, input int a2,
                                            input int a3, input int a4);
        logic [4:0][15:0] rv;
        rv[0] = 16'(a0); rv[1] = 16'(a1); rv[2] = 16'(a2);
        rv[3] = 16'(a3); rv[4] = 16'(a4);
        return rv;
    endfunction

    // Reference: plain per-block sums, clipped once at the end (clipping is
    // monotone, so this equals per-step saturation), argmin with lowest index on ties.
    task automatic model_accept(input logic [4:0][15:0] rv, input longint when);
        exp_t   e;
        longint s;
        for (int k = 0; k < 5; k++) msum[k] += absv(rv[k]);
        mcnt++;
        if (mcnt == BS) begin
            e.order = 0;
            e.sum   = (msum[0] > MAXS) ? MAXS : msum[0];
            for (int k = 1; k < 5; k++) begin
                s = (msum[k] > MAXS) ? MAXS : msum[k];
                if (s < e.sum) begin
                    e.order = k;
                    e.sum   = s;
                end
            end
            e.cyc = when;
            expq.push_back(e);
            for (int k = 0; k < 5; k++) msum[k] = 0;
            mcnt = 0;
        end
    endtask

    // One clock of stimulus, driven on the falling edge; an accepted sample is
    // taken at the next rising edge (cycle cyc+1) and its block result is due 6 later.
    task automatic cycle(input bit en, input bit vld, input logic [4:0][15:0] rv);
        @(negedge iClock);
        iEnable    = en;
        iValid     = vld;
        iResidual0 = rv[0];
        iResidual1 = rv[1];
        iResidual2 = rv[2];
        iResidual3 = rv[3];
        iResidual4 = rv[4];
        if (en && vld) model_accept(rv, cyc + 7);
    endtask

    task automatic block_const(input logic [4:0][15:0] rv);
        for (int i = 0; i < BS; i++) cycle(1'b1, 1'b1, rv);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, mk(0, 0, 0, 0, 0));
    endtask

    task automatic do_reset();
        @(negedge iClock);
        iReset  = 1'b1;
        iValid  = 1'b0;
        iEnable = 1'b0;
        expq.delete();
        for (int k = 0; k < 5; k++) msum[k] = 0;
        mcnt = 0;
        @(negedge iClock);
        check("reset_oDone", longint'(oDone), 0);
        check("reset_oBestOrder", longint'(oBestOrder), 0);
        check("reset_oBestSum", longint'(oBestSum), 0);
        iReset = 1'b0;
    endtask

    function automatic int rnd_res(input int mode);
        int pick;
        case (mode)
            0: return int'($urandom_range(0, 65535)) - 32768;
            1: return int'($urandom_range(0, 8)) - 4;
            default: begin
                pick = int'($urandom_range(0, 3));
                case (pick)
                    0: return -32768;
                    1: return 32767;
                    2: return -1;
                    default: return 0;
                endcase
            end
        endcase
    endfunction

    // Monitor: pops one expectation per oDone pulse.
    always @(negedge iClock) begin
        exp_t e;
        if (oDone) begin
            checks++;
            if (done_prev) begin
                errors++;
                $display("FAIL done_consecutive: oDone high two cycles in a row at cycle %0d", cyc);
            end
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: oDone at cycle %0d with nothing expected (order %0d sum %0d)",
                         cyc, oBestOrder, oBestSum);
            end else begin
                e = expq.pop_front();
                check("best_order", longint'(oBestOrder), longint'(e.order));
                check("best_sum", longint'(oBestSum), e.sum);
                check("done_cycle", cyc, e.cyc);
            end
        end
        done_prev = oDone;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int mode;
        iReset = 1'b1; iEnable = 1'b0; iValid = 1'b0;
        iResidual0 = '0; iResidual1 = '0; iResidual2 = '0; iResidual3 = '0; iResidual4 = '0;
        for (int k = 0; k < 5; k++) msum[k] = 0;

        do_reset();
        idle(2);

        block_const(mk(5, 10, 10, 10, 10));          // order 0, sum 40
        idle(10);
        block_const(mk(3, 3, 3, -2, 3));              // order 3, sum 16
        idle(10);
        block_const(mk(7, 1, 1, 7, 7));               // tie -> order 1, sum 8
        idle(10);

        block_const(mk(20, 20, 20, 20, 1));           // back-to-back: order 4
        block_const(mk(9, 9, -3, 9, 9));              //               order 2
        idle(10);

        block_const(mk(-32768, -32768, -32768, -32768, -32768));  // saturates -> 131071, order 0
        idle(10);

        // iValid toggling plus iEnable gating stretches the block.
        for (int i = 0; i < 20; i++)
            cycle((i % 5) != 4, (i % 2) == 0, mk(i, 2 * i, -i, 3, i - 5));
        idle(12);

        // Partial block discarded by reset, then a fresh block.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, mk(1, 1, 1, 1, 1));
        do_reset();
        block_const(mk(4, -6, 2, 8, 5));
        idle(12);

        // Reset while the compare is running: no oDone, outputs stay cleared.
        block_const(mk(11, 2, 13, 14, 15));
        idle(1);
        do_reset();
        idle(15);
        check("post_cmp_reset_order", longint'(oBestOrder), 0);
        check("post_cmp_reset_sum", longint'(oBestSum), 0);

        // Randomized blocks with random gaps, occasionally back-to-back.
        for (int b = 0; b < 16; b++) begin
            mode = int'($urandom_range(0, 2));
            acc  = 0;
            while (acc < BS) begin
                bit en;
                bit vld;
                en  = ($urandom_range(0, 7) != 0);
                vld = ($urandom_range(0, 3) != 0);
                cycle(en, vld, mk(rnd_res(mode), rnd_res(mode), rnd_res(mode),
                                  rnd_res(mode), rnd_res(mode)));
                if (en && vld) acc++;
            end
            if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 6)));
        end
        idle(20);

        check("queue_empty", longint'(expq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
